calc_cmd_driver: RTL

- Initiator-side sequencer for the serial calculator command protocol (`iniciar`/`dados`/`pronto`/`result`).
- Accepts one parallel operation (a, b, opcode) on a valid/ready request port and drives the 4-word command sequence on the calculator's input pins.
- Waits for `pronto`, captures the result and presents it on a valid/ready response port.
- Sits between a host/test-sequencer and one fsm-style calculator instance.

---
 rtl/calc_cmd_driver_pkg.sv | 28 ++
 rtl/calc_cmd_driver_watchdog.sv | 30 +++
 rtl/calc_cmd_driver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/calc_cmd_driver_pkg.sv
// Shared calculator types, driver constants and the driver state encoding.
package definitions;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } opcodes_t;

    typedef logic [7:0] result_t;

    localparam int CALC_OPERAND_WIDTH = 4;
    localparam int CALC_OPCODE_WIDTH  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND_A,
        ST_SEND_B,
        ST_SEND_OP,
        ST_WAIT_DONE,
        ST_RESP
    } calc_drv_state_t;

endpackage

// File: rtl/calc_cmd_driver_watchdog.sv
// Cycle counter for the WAIT_DONE phase; expired_o is high during the
// TIMEOUT_CYCLES-th enabled cycle after a clear, and stays high until cleared.
module calc_drv_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/calc_cmd_driver.sv
// Sequences one (a, b, op) request into iniciar + 3 dados words and returns the calculator result.
// Latency: handshake H -> iniciar H+1 -> rsp_valid one cycle after pronto (H+7 with a compliant calculator).
// Backpressure: req_ready only in IDLE; RESP holds until rsp_ready. CALC_DRV_TIMEOUT_EN adds the WAIT_DONE abort.
module calc_cmd_driver
    import definitions::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int OPERAND_WIDTH  = CALC_OPERAND_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPERAND_WIDTH-1:0] req_a,
    input  logic [OPERAND_WIDTH-1:0] req_b,
    input  opcodes_t                 req_op,
    output logic                     iniciar,
    output logic [WORD_WIDTH-1:0]    dados,
    input  logic                     pronto,
    input  result_t                  result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output result_t                  rsp_result,
    output logic                     rsp_err
);

    if ((OPERAND_WIDTH > WORD_WIDTH) || (CALC_OPCODE_WIDTH > WORD_WIDTH) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
        $error("calc_cmd_driver: illegal parameter combination");
    end

    calc_drv_state_t            state_q;
    logic [OPERAND_WIDTH-1:0]   a_q;
    logic [OPERAND_WIDTH-1:0]   b_q;
    opcodes_t                   op_q;
    logic                       req_ready_q;
    logic                       iniciar_q;
    logic [WORD_WIDTH-1:0]      dados_q;
    logic                       rsp_valid_q;
    result_t                    rsp_result_q;
    logic                       rsp_err_q;
    logic                       timeout_w;

`ifdef CALC_DRV_TIMEOUT_EN
    calc_drv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_SEND_OP),
        .en_i      (state_q == ST_WAIT_DONE),
        .expired_o (timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    // Outputs are registered: each transition loads the values of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            req_ready_q  <= 1'b1;
            iniciar_q    <= 1'b0;
            dados_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        op_q        <= req_op;
                        req_ready_q <= 1'b0;
                        iniciar_q   <= 1'b1;
                        dados_q     <= '0;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    iniciar_q <= 1'b0;
                    dados_q   <= WORD_WIDTH'(a_q);
                    state_q   <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    dados_q <= WORD_WIDTH'(b_q);
                    state_q <= ST_SEND_B;
                end
                ST_SEND_B: begin
                    dados_q <= WORD_WIDTH'(op_q);
                    state_q <= ST_SEND_OP;
                end
                ST_SEND_OP: begin
                    dados_q <= '0;
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // pronto takes priority over a timeout expiring in the same cycle
                    if (pronto) begin
                        rsp_result_q <= result;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (timeout_w) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    iniciar_q   <= 1'b0;
                    dados_q     <= '0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign iniciar    = iniciar_q;
    assign dados      = dados_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule
